ram_stream_reader: RTL and testbench
====================================

RAM_STREAM_READER -- requirements
Module: ram_stream_reader

Interface
REQ-001 Parameter W, default 16, RAM word width in bits.
REQ-002 Parameter D, default 1024, RAM depth in words; power of two; address index width is clog2(D).
REQ-003 Clocking: one clock; reset is synchronous and active-high.
REQ-004 clk  in  1  sole clock; all state updates on rising edge.
REQ-005 rst  in  1  synchronous, active-high reset.
REQ-006 cmd_valid  in  1  read command offered.
REQ-007 cmd_ready  out  1  block can accept a command.
REQ-008 cmd_base  in  32  first word address.
REQ-009 cmd_len  in  32  number of words to read; 0 is legal.
REQ-010 ram_re  out  1  read enable to simple dual-port RAM.
REQ-011 ram_read_addr  out  32  read address; upper bits above clog2(D) are zero.
REQ-012 ram_dout_vld  in  1  RAM read data valid, one cycle after ram_re.
REQ-013 ram_dout  in  W  RAM read data.
REQ-014 out_valid  out  1  stream word available.
REQ-015 out_ready  in  1  downstream accepts word.
REQ-016 out_data  out  W  stream word.
REQ-017 out_last  out  1  marks final word of a command.
REQ-018 busy  out  1  high from command accept until final word popped.
REQ-019 done  out  1  one-cycle pulse on command completion.

Function
REQ-020 FSM states IDLE, READ, DRAIN; cmd_ready high only in IDLE; command accepted when cmd_valid and cmd_ready both high.
REQ-021 IDLE to READ on accept with cmd_len > 0; latch base, len, remaining = cmd_len, word index i = 0.
REQ-022 Accept with cmd_len = 0: no ram_re issued, done pulses the following cycle, state stays IDLE.
REQ-023 Word i address = (cmd_base + i) mod D; wrap from D-1 to 0 without stall.
REQ-024 Exactly one ram_re cycle per word; ram_re never asserted in IDLE or DRAIN.
REQ-025 Two-entry output FIFO; ram_re asserted in cycle t only if fifo occupancy + in-flight reads - pop(t) <= 1, guaranteeing no overflow.
REQ-026 Data captured into FIFO only on ram_dout_vld; ram_dout_vld with no read in flight is ignored.
REQ-027 Timing: accept at edge 0, first ram_re in cycle 1, ram_dout_vld in cycle 2, out_valid first high in cycle 3.
REQ-028 With out_ready held high, sustained throughput is one word per cycle; N words complete N+2 cycles after first ram_re.
REQ-029 Pop occurs when out_valid and out_ready both high; out_data/out_last stable while out_valid high and out_ready low.
REQ-030 out_last high exactly with word cmd_len-1.
REQ-031 READ to DRAIN after last ram_re; DRAIN to IDLE when last word popped; done pulses the cycle after that pop; busy low in same cycle as done.
REQ-032 Simultaneous push and pop on a full FIFO is legal; occupancy unchanged, order preserved.
REQ-033 cmd_len arithmetic 32-bit; lengths above D re-read wrapped addresses.

Reset
REQ-034 On rst: state IDLE, FIFO empty, in-flight cleared; cmd_ready=1 in the cycle after reset, ram_re=0, ram_read_addr=0, out_valid=0, out_data=0, out_last=0, busy=0, done=0.
REQ-035 Reset mid-command abandons the command; a ram_dout_vld in the cycle after reset is discarded.

Structure
REQ-036 Shared package ram_rd_pkg holds the FSM state enum and FIFO depth constant (2).
REQ-037 Sub-module ram_rd_fifo implements the 2-entry FIFO with count; FSM and address generation reside in ram_stream_reader.

Verification
REQ-038 Base 5, len 4, out_ready=1 -> ram_re cycles 1-4 at addresses 5,6,7,8; out_data = RAM[5..8] cycles 3-6; out_last cycle 6; done cycle 7.
REQ-039 Base 1022, len 4, D=1024 -> addresses 1022,1023,0,1; data in that order.
REQ-040 Len 8, out_ready toggled 1,0,0,1 repeating -> no word dropped or duplicated; ram_re never issued when FIFO plus in-flight reach 2.
REQ-041 Len 0 -> no ram_re, no out_valid, done one cycle after accept.
REQ-042 rst asserted after 2 of 6 words popped -> outputs at reset values next cycle; late ram_dout_vld ignored; new command base 0, len 2 completes correctly.
REQ-043 Spurious ram_dout_vld while IDLE -> out_valid remains 0.

Source files
------------

// File: rtl/ram_rd_pkg.sv
// Shared definitions for the RAM stream reader: controller states and output FIFO sizing.
package ram_rd_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_READ  = 2'd1,
        ST_DRAIN = 2'd2
    } state_t;

    localparam int FIFO_DEPTH = 2;
    localparam int FIFO_CNT_W = $clog2(FIFO_DEPTH + 1);
    localparam int FIFO_PTR_W = $clog2(FIFO_DEPTH);
    localparam logic [FIFO_CNT_W-1:0] FIFO_FULL = FIFO_CNT_W'(FIFO_DEPTH);

endpackage

// File: rtl/ram_rd_fifo.sv
// Two-entry output FIFO with occupancy count; supports push and pop in the same cycle when full.
module ram_rd_fifo
    import ram_rd_pkg::*;
#(
    parameter int W = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  i_push,
    input  logic [W-1:0]          i_data,
    input  logic                  i_pop,
    output logic                  o_valid,
    output logic [W-1:0]          o_data,
    output logic [FIFO_CNT_W-1:0] o_count
);

    logic [W-1:0]          r_mem [FIFO_DEPTH];
    logic [FIFO_PTR_W-1:0] r_wr_ptr;
    logic [FIFO_PTR_W-1:0] r_rd_ptr;
    logic [FIFO_CNT_W-1:0] r_count;
    logic                  w_pop;
    logic                  w_push;

    assign w_pop  = i_pop && (r_count != '0);
    assign w_push = i_push && ((r_count != FIFO_FULL) || w_pop);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + FIFO_PTR_W'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + FIFO_PTR_W'(1);
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + FIFO_CNT_W'(1);
                2'b01:   r_count <= r_count - FIFO_CNT_W'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    // Storage carries no reset; the empty FIFO presents zero on its data output instead.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= i_data;
        end
    end

    assign o_valid = (r_count != '0);
    assign o_data  = o_valid ? r_mem[r_rd_ptr] : '0;
    assign o_count = r_count;

endmodule

// File: rtl/ram_stream_reader.sv
// Streams cmd_len words from a simple dual-port RAM starting at cmd_base, wrapping at depth D,
// through a two-entry FIFO with valid/ready backpressure.
module ram_stream_reader
    import ram_rd_pkg::*;
#(
    parameter int W = 16,
    parameter int D = 1024
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          cmd_valid,
    output logic          cmd_ready,
    input  logic [31:0]   cmd_base,
    input  logic [31:0]   cmd_len,
    output logic          ram_re,
    output logic [31:0]   ram_read_addr,
    input  logic          ram_dout_vld,
    input  logic [W-1:0]  ram_dout,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [W-1:0]  out_data,
    output logic          out_last,
    output logic          busy,
    output logic          done
);

    localparam int AW = $clog2(D);
    localparam logic [FIFO_CNT_W:0] OCC_ONE = (FIFO_CNT_W + 1)'(1);
    localparam logic [FIFO_CNT_W:0] OCC_TWO = (FIFO_CNT_W + 1)'(2);

    state_t                r_state;
    logic [AW-1:0]         r_addr;
    logic [31:0]           r_remaining;
    logic [31:0]           r_pop_left;
    logic                  r_inflight;
    logic                  r_done;

    logic                  w_accept;
    logic                  w_pop;
    logic                  w_push;
    logic                  w_last_pop;
    logic [FIFO_CNT_W-1:0] w_fifo_cnt;
    logic [FIFO_CNT_W:0]   w_occ;
    logic                  w_unused_base;

    assign cmd_ready  = (r_state == ST_IDLE);
    assign w_accept   = cmd_valid && cmd_ready;
    assign w_pop      = out_valid && out_ready;
    assign w_push     = ram_dout_vld && r_inflight;
    assign w_last_pop = w_pop && (r_pop_left == 32'd1);

    // A read is issued only if its word is guaranteed a FIFO slot on arrival.
    assign w_occ  = {1'b0, w_fifo_cnt} + {{FIFO_CNT_W{1'b0}}, r_inflight};
    assign ram_re = (r_state == ST_READ) && (w_occ <= (w_pop ? OCC_TWO : OCC_ONE));

    assign ram_read_addr = {{(32 - AW){1'b0}}, r_addr};
    assign out_last      = out_valid && (r_pop_left == 32'd1);
    assign busy          = (r_state != ST_IDLE);
    assign done          = r_done;
    assign w_unused_base = ^cmd_base[31:AW];

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= ST_IDLE;
            r_addr      <= '0;
            r_remaining <= '0;
            r_pop_left  <= '0;
            r_inflight  <= 1'b0;
            r_done      <= 1'b0;
        end else begin
            r_inflight <= ram_re;
            r_done     <= (w_accept && (cmd_len == 32'd0)) || w_last_pop;
            if (w_pop) begin
                r_pop_left <= r_pop_left - 32'd1;
            end
            case (r_state)
                ST_IDLE: begin
                    if (w_accept && (cmd_len != 32'd0)) begin
                        r_state     <= ST_READ;
                        r_addr      <= cmd_base[AW-1:0];
                        r_remaining <= cmd_len;
                        r_pop_left  <= cmd_len;
                    end
                end
                ST_READ: begin
                    if (ram_re) begin
                        r_addr      <= r_addr + AW'(1);
                        r_remaining <= r_remaining - 32'd1;
                        if (r_remaining == 32'd1) begin
                            r_state <= ST_DRAIN;
                        end
                    end
                end
                ST_DRAIN: begin
                    if (w_last_pop) begin
                        r_state <= ST_IDLE;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    ram_rd_fifo #(
        .W (W)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .i_push  (w_push),
        .i_data  (ram_dout),
        .i_pop   (w_pop),
        .o_valid (out_valid),
        .o_data  (out_data),
        .o_count (w_fifo_cnt)
    );

endmodule

// File: tb/tb_ram_stream_reader.sv
// Randomized scoreboard bench for ram_stream_reader with a behavioural RAM and reference queues.
module tb_ram_stream_reader;

    localparam int W  = 16;
    localparam int D  = 1024;
    localparam int AW = 10;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          cmd_valid = 1'b0;
    logic          cmd_ready;
    logic [31:0]   cmd_base = '0;
    logic [31:0]   cmd_len = '0;
    logic          ram_re;
    logic [31:0]   ram_read_addr;
    logic          ram_dout_vld;
    logic [W-1:0]  ram_dout;
    logic          out_valid;
    logic          out_ready = 1'b1;
    logic [W-1:0]  out_data;
    logic          out_last;
    logic          busy;
    logic          done;

    ram_stream_reader #(.W(W), .D(D)) dut (
        .clk           (clk),
        .rst           (rst),
        .cmd_valid     (cmd_valid),
        .cmd_ready     (cmd_ready),
        .cmd_base      (cmd_base),
        .cmd_len       (cmd_len),
        .ram_re        (ram_re),
        .ram_read_addr (ram_read_addr),
        .ram_dout_vld  (ram_dout_vld),
        .ram_dout      (ram_dout),
        .out_valid     (out_valid),
        .out_ready     (out_ready),
        .out_data      (out_data),
        .out_last      (out_last),
        .busy          (busy),
        .done          (done)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [W-1:0] d;
        logic         last;
    } exp_t;

    exp_t        exp_q[$];
    logic [31:0] addr_q[$];
    logic [W-1:0] mem [D];
    int n_pass  = 0;
    int n_total = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_total++;
        if (act === req) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h", name, act, req);
    endtask

    // Behavioural RAM: data one cycle after ram_re, plus an injectable spurious valid.
    logic         r_vld = 1'b0;
    logic [W-1:0] r_dat = '0;
    logic         spurious = 1'b0;
    always @(posedge clk) begin
        r_vld <= ram_re;
        if (ram_re) r_dat <= mem[ram_read_addr[AW-1:0]];
    end
    assign ram_dout_vld = r_vld | spurious;
    assign ram_dout     = r_dat;

    int ready_mode = 0;
    int ready_idx  = 0;
    initial forever begin
        @(posedge clk);
        #1;
        case (ready_mode)
            0: out_ready = 1'b1;
            1: out_ready = 1'($urandom_range(0, 1));
            default: begin
                out_ready = ((ready_idx % 4) == 0) || ((ready_idx % 4) == 3);
                ready_idx++;
            end
        endcase
    end

    logic m_busy = 1'b0;
    logic m_done_exp = 1'b0;
    logic m_rst_chk = 1'b0;
    int   m_iss = 0;
    int   m_pops = 0;

    always @(negedge clk) begin
        logic        pop_now;
        exp_t        e;
        logic [31:0] a;
        if (rst) begin
            exp_q.delete();
            addr_q.delete();
            m_busy     = 1'b0;
            m_done_exp = 1'b0;
            m_rst_chk  = 1'b1;
            m_iss      = 0;
            m_pops     = 0;
        end else begin
            pop_now = out_valid && out_ready;
            if (m_rst_chk) begin
                check("reset_ctrl {ov,last,re,busy,done,rdy}",
                      {26'd0, out_valid, out_last, ram_re, busy, done, cmd_ready}, 32'b000001);
                check("reset_out_data", 32'(out_data), 32'd0);
                check("reset_ram_addr", ram_read_addr, 32'd0);
                m_rst_chk = 1'b0;
            end
            check("busy", 32'(busy), 32'(m_busy));
            check("cmd_ready", 32'(cmd_ready), 32'(!m_busy));
            if (done || m_done_exp) check("done", 32'(done), 32'(m_done_exp));
            m_done_exp = 1'b0;
            if (ram_re) begin
                check("ram_re_expected", 32'(addr_q.size() != 0), 32'd1);
                if (addr_q.size() != 0) begin
                    a = addr_q.pop_front();
                    check("ram_addr", ram_read_addr, a);
                end
                check("occupancy_le_1", 32'((m_iss - m_pops - int'(pop_now)) <= 1), 32'd1);
                m_iss++;
            end
            if (pop_now) begin
                m_pops++;
                check("pop_expected", 32'(exp_q.size() != 0), 32'd1);
                if (exp_q.size() != 0) begin
                    e = exp_q.pop_front();
                    check("out_data", 32'(out_data), 32'(e.d));
                    check("out_last", 32'(out_last), 32'(e.last));
                    if (e.last) begin
                        m_done_exp = 1'b1;
                        m_busy     = 1'b0;
                    end
                end
            end
            if (cmd_valid && cmd_ready) begin
                if (cmd_len == 32'd0) m_done_exp = 1'b1;
                else m_busy = 1'b1;
            end
        end
    end

    // Called at posedge+1; returns at posedge+1 of the cycle after acceptance.
    task automatic issue(input logic [31:0] base, input logic [31:0] len);
        int          waited = 0;
        logic [31:0] a;
        while (!cmd_ready && waited < 5000) begin
            @(posedge clk);
            #1;
            waited++;
        end
        check("cmd_ready_wait", 32'(cmd_ready), 32'd1);
        for (int i = 0; i < int'(len); i++) begin
            a = base + 32'(i);
            addr_q.push_back(a % D);
            exp_q.push_back('{d: mem[a[AW-1:0]], last: (i == int'(len) - 1)});
        end
        cmd_base  = base;
        cmd_len   = len;
        cmd_valid = 1'b1;
        @(posedge clk);
        #1;
        cmd_valid = 1'b0;
    endtask

    task automatic wait_idle();
        int n = 0;
        while ((busy || m_busy || exp_q.size() != 0) && n < 5000) begin
            @(posedge clk);
            #1;
            n++;
        end
        check("drain_in_time", 32'(n < 5000), 32'd1);
        repeat (2) begin
            @(posedge clk);
            #1;
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [8:0] v_re, v_ov, v_last, v_done;
        int         start;
        int         n;
        logic [31:0] len;
        for (int i = 0; i < D; i++) mem[i] = W'($urandom);
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        @(posedge clk);
        #1;

        // Directed timing: base 5, len 4, ready held high.
        ready_mode = 0;
        v_re = '0; v_ov = '0; v_last = '0; v_done = '0;
        issue(32'd5, 32'd4);
        for (int c = 1; c <= 8; c++) begin
            @(negedge clk);
            v_re[c]   = ram_re;
            v_ov[c]   = out_valid;
            v_last[c] = out_last;
            v_done[c] = done;
        end
        check("timing_ram_re", 32'(v_re), 32'b000011110);
        check("timing_out_valid", 32'(v_ov), 32'b001111000);
        check("timing_out_last", 32'(v_last), 32'b001000000);
        check("timing_done", 32'(v_done), 32'b010000000);
        @(posedge clk);
        #1;
        wait_idle();

        // Address wrap at the top of the RAM.
        issue(32'd1022, 32'd4);
        wait_idle();

        // Backpressure pattern 1,0,0,1.
        ready_mode = 2;
        ready_idx  = 0;
        issue(32'd100, 32'd8);
        wait_idle();

        // Zero-length command.
        ready_mode = 0;
        issue(32'd77, 32'd0);
        wait_idle();

        // Spurious RAM valid while idle.
        spurious = 1'b1;
        @(posedge clk);
        #1;
        spurious = 1'b0;
        repeat (2) begin
            @(negedge clk);
            check("idle_spurious_out_valid", 32'(out_valid), 32'd0);
        end
        @(posedge clk);
        #1;

        // Reset after two of six words popped.
        start = m_pops;
        issue(32'd300, 32'd6);
        n = 0;
        while (m_pops < start + 2 && n < 100) begin
            @(posedge clk);
            #1;
            n++;
        end
        check("two_pops_in_time", 32'(n < 100), 32'd1);
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst      = 1'b0;
        spurious = 1'b1;
        @(posedge clk);
        #1;
        spurious = 1'b0;
        repeat (2) begin
            @(negedge clk);
            check("post_reset_out_valid", 32'(out_valid), 32'd0);
        end
        @(posedge clk);
        #1;
        issue(32'd0, 32'd2);
        wait_idle();

        // Randomized back-to-back commands with random backpressure.
        ready_mode = 1;
        for (int k = 0; k < 16; k++) begin
            len = ($urandom_range(0, 3) == 0) ? 32'd0 : 32'($urandom_range(1, 24));
            issue($urandom, len);
        end
        issue($urandom, 32'd1030);
        wait_idle();

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
